// File: rtl/booth_r8_controller.sv
// Sequencer for a radix-8 Booth multiplier datapath: load, precompute 3M, one digit per
// cycle of accumulate+shift, then a one-cycle Done pulse.
module booth_r8_controller #(
    parameter  int WIDTH = 12,
    localparam int NDIG  = (WIDTH + 2) / 3,
    localparam int CNT_W = $clog2(NDIG) + 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [3:0]       i_digit,
    output logic             o_load,
    output logic             o_calc3m,
    output logic             o_acc_en,
    output logic             o_shift,
    output logic [2:0]       o_sel,
    output logic             o_neg,
    output logic             o_busy,
    output logic             o_done,
    output logic [2:0]       o_state,
    output logic [CNT_W-1:0] o_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'b000,
        S_LOAD  = 3'b001,
        S_PRE3M = 3'b010,
        S_STEP  = 3'b011,
        S_DONE  = 3'b100
    } state_t;

    localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic             w_step;
    logic [2:0]       w_sel;
    logic             w_neg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_count <= '0;
        end else begin
            case (r_state)
                S_IDLE:  if (i_start) r_state <= S_LOAD;
                S_LOAD:  r_state <= S_PRE3M;
                S_PRE3M: begin
                    r_state <= S_STEP;
                    r_count <= '0;
                end
                S_STEP: begin
                    if (r_count < LAST_DIG) r_count <= r_count + CNT_W'(1);
                    else                    r_state <= S_DONE;
                end
                S_DONE:  r_state <= i_start ? S_LOAD : S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_step = (r_state == S_STEP);

    // Booth digit value = -4*d3 + 2*d2 + d1 + d0, split into magnitude and sign
    always_comb begin
        w_sel = 3'd0;
        w_neg = 1'b0;
        case (i_digit)
            4'b0001, 4'b0010: w_sel = 3'd1;
            4'b0011, 4'b0100: w_sel = 3'd2;
            4'b0101, 4'b0110: w_sel = 3'd3;
            4'b0111:          w_sel = 3'd4;
            4'b1000:          begin w_sel = 3'd4; w_neg = 1'b1; end
            4'b1001, 4'b1010: begin w_sel = 3'd3; w_neg = 1'b1; end
            4'b1011, 4'b1100: begin w_sel = 3'd2; w_neg = 1'b1; end
            4'b1101, 4'b1110: begin w_sel = 3'd1; w_neg = 1'b1; end
            default:          begin w_sel = 3'd0; w_neg = 1'b0; end
        endcase
    end

    assign o_sel    = w_step ? w_sel : 3'd0;
    assign o_neg    = w_step & w_neg;
    assign o_load   = (r_state == S_LOAD);
    assign o_calc3m = (r_state == S_PRE3M);
    assign o_acc_en = w_step;
    assign o_shift  = w_step;
    assign o_done   = (r_state == S_DONE);
    assign o_busy   = o_load | o_calc3m | w_step;
    assign o_state  = r_state;
    assign o_count  = r_count;

endmodule

// File: tb/tb_booth_r8_controller.sv
// Directed bench for booth_r8_controller: a WIDTH=12 instance for sequencing and decode,
// and a WIDTH=8 instance for the shorter digit count.
`timescale 1ns/100ps
module tb_booth_r8_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, start8;
    logic [3:0] digit, digit8;

    logic       load, calc3m, acc_en, shift, neg, busy, done;
    logic [2:0] sel, state, count;
    logic       load8, calc3m8, acc_en8, shift8, neg8, busy8, done8;
    logic [2:0] sel8, state8, count8;

    int total = 0;
    int bad   = 0;

    always #20 clk = ~clk;

    booth_r8_controller #(.WIDTH(12)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_digit(digit),
        .o_load(load), .o_calc3m(calc3m), .o_acc_en(acc_en), .o_shift(shift),
        .o_sel(sel), .o_neg(neg), .o_busy(busy), .o_done(done),
        .o_state(state), .o_count(count)
    );

    booth_r8_controller #(.WIDTH(8)) dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start8), .i_digit(digit8),
        .o_load(load8), .o_calc3m(calc3m8), .o_acc_en(acc_en8), .o_shift(shift8),
        .o_sel(sel8), .o_neg(neg8), .o_busy(busy8), .o_done(done8),
        .o_state(state8), .o_count(count8)
    );

    // Expected {state, load, calc3m, acc_en, shift, busy, done, count}
    function automatic logic [11:0] mk(input logic [2:0] st, input logic [2:0] cnt);
        logic [5:0] f;
        case (st)
            3'b001:  f = 6'b100010;
            3'b010:  f = 6'b010010;
            3'b011:  f = 6'b001110;
            3'b100:  f = 6'b000001;
            default: f = 6'b000000;
        endcase
        return {st, f, cnt};
    endfunction

    task automatic chk(input logic [15:0] obs, input logic [15:0] exp, input string tag);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk12(input logic [2:0] st, input logic [2:0] cnt, input logic [3:0] sn,
                         input string tag);
        chk({4'h0, state, load, calc3m, acc_en, shift, busy, done, count},
            {4'h0, mk(st, cnt)}, tag);
        chk({12'h0, sel, neg}, {12'h0, sn}, {tag, "_selneg"});
        $display("%0t %s state=%b cnt=%0d sel=%0d neg=%b", $time, tag, state, count, sel, neg);
    endtask

    task automatic chk8(input logic [2:0] st, input logic [2:0] cnt, input string tag);
        chk({4'h0, state8, load8, calc3m8, acc_en8, shift8, busy8, done8, count8},
            {4'h0, mk(st, cnt)}, tag);
        $display("%0t %s state=%b cnt=%0d", $time, tag, state8, count8);
    endtask

    task automatic adv(input logic s);
        start = s;
        @(posedge clk);
        #1;
    endtask

    task automatic adv8(input logic s);
        start8 = s;
        @(posedge clk);
        #1;
    endtask

    logic [2:0]  sel_tab [16];
    logic [15:0] neg_tab;

    initial begin
        sel_tab = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4,
                    3'd4, 3'd3, 3'd3, 3'd2, 3'd2, 3'd1, 3'd1, 3'd0};
        neg_tab = 16'h7F00;
        rst_n  = 1'b0;
        start  = 1'b1;
        start8 = 1'b0;
        digit  = 4'b0111;
        digit8 = 4'b0000;

        // Reset held with Start high: IDLE, everything zero
        @(posedge clk); @(posedge clk); #1;
        chk12(3'b000, 3'd0, 4'h0, "reset");
        rst_n = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            adv(1'b0);
            chk12(3'b000, 3'd0, 4'h0, "idle_hold");
        end

        // Basic sequence; Digit=0111 shows +4 only while stepping
        adv(1'b1); chk12(3'b001, 3'd0, 4'h0, "op1_load");
        adv(1'b0); chk12(3'b010, 3'd0, 4'h0, "op1_pre3m");
        for (int i = 0; i < 4; i++) begin
            adv(1'b0); chk12(3'b011, 3'(i), {3'd4, 1'b0}, "op1_step");
        end
        adv(1'b0); chk12(3'b100, 3'd3, 4'h0, "op1_done");
        adv(1'b0); chk12(3'b000, 3'd3, 4'h0, "op1_idle");

        // Full digit sweep inside the first STEP cycle
        adv(1'b1); chk12(3'b001, 3'd3, 4'h0, "op2_load");
        adv(1'b0); chk12(3'b010, 3'd3, 4'h0, "op2_pre3m");
        adv(1'b0);
        for (int d = 0; d < 16; d++) begin
            digit = 4'(d);
            #1;
            chk({12'h0, sel, neg}, {12'h0, sel_tab[d], neg_tab[d]}, $sformatf("decode_%b", 4'(d)));
            $display("%0t decode digit=%b sel=%0d neg=%b", $time, digit, sel, neg);
        end
        digit = 4'b0000;
        #1;
        chk12(3'b011, 3'd0, 4'h0, "op2_step0");
        for (int i = 1; i < 4; i++) begin
            adv(1'b0); chk12(3'b011, 3'(i), 4'h0, "op2_step");
        end
        adv(1'b0); chk12(3'b100, 3'd3, 4'h0, "op2_done");
        adv(1'b0); chk12(3'b000, 3'd3, 4'h0, "op2_idle");

        // Start pulses mid-operation are ignored; Start held through DONE chains a second op
        digit = 4'b1101;
        adv(1'b1); chk12(3'b001, 3'd3, 4'h0, "op3_load");
        adv(1'b0); chk12(3'b010, 3'd3, 4'h0, "op3_pre3m");
        adv(1'b0); chk12(3'b011, 3'd0, {3'd1, 1'b1}, "op3_step");
        adv(1'b1); chk12(3'b011, 3'd1, {3'd1, 1'b1}, "op3_step");
        adv(1'b0); chk12(3'b011, 3'd2, {3'd1, 1'b1}, "op3_step");
        adv(1'b1); chk12(3'b011, 3'd3, {3'd1, 1'b1}, "op3_step");
        adv(1'b1); chk12(3'b100, 3'd3, 4'h0, "op3_done");
        adv(1'b1); chk12(3'b001, 3'd3, 4'h0, "op4_load");
        adv(1'b0); chk12(3'b010, 3'd3, 4'h0, "op4_pre3m");
        for (int i = 0; i < 4; i++) begin
            adv(1'b0); chk12(3'b011, 3'(i), {3'd1, 1'b1}, "op4_step");
        end
        adv(1'b0); chk12(3'b100, 3'd3, 4'h0, "op4_done");
        adv(1'b0); chk12(3'b000, 3'd3, 4'h0, "op4_idle");

        // Asynchronous reset in the middle of STEP aborts without Done
        digit = 4'b1000;
        adv(1'b1); chk12(3'b001, 3'd3, 4'h0, "op5_load");
        adv(1'b0); chk12(3'b010, 3'd3, 4'h0, "op5_pre3m");
        adv(1'b0); chk12(3'b011, 3'd0, {3'd4, 1'b1}, "op5_step");
        adv(1'b0); chk12(3'b011, 3'd1, {3'd4, 1'b1}, "op5_step");
        adv(1'b0); chk12(3'b011, 3'd2, {3'd4, 1'b1}, "op5_step");
        #5 rst_n = 1'b0;
        #1 chk12(3'b000, 3'd0, 4'h0, "abort_async");
        adv(1'b0); chk12(3'b000, 3'd0, 4'h0, "abort_held");
        rst_n = 1'b1;
        adv(1'b0); chk12(3'b000, 3'd0, 4'h0, "abort_nodone");
        adv(1'b1); chk12(3'b001, 3'd0, 4'h0, "op6_load");
        adv(1'b0); chk12(3'b010, 3'd0, 4'h0, "op6_pre3m");
        for (int i = 0; i < 4; i++) begin
            adv(1'b0); chk12(3'b011, 3'(i), {3'd4, 1'b1}, "op6_step");
        end
        adv(1'b0); chk12(3'b100, 3'd3, 4'h0, "op6_done");
        adv(1'b0); chk12(3'b000, 3'd3, 4'h0, "op6_idle");

        // Eight-bit operands use three digits
        adv8(1'b1); chk8(3'b001, 3'd0, "w8_load");
        adv8(1'b0); chk8(3'b010, 3'd0, "w8_pre3m");
        for (int i = 0; i < 3; i++) begin
            adv8(1'b0); chk8(3'b011, 3'(i), "w8_step");
        end
        adv8(1'b0); chk8(3'b100, 3'd2, "w8_done");
        adv8(1'b0); chk8(3'b000, 3'd2, "w8_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
